// File: rtl/clockdiv_multi.sv
// Multi-channel programmable clock divider with per-channel duty cycle,
// double-buffered divisor/high-time updates and a shared phase-align sync.
module clockdiv_multi #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] divideby,
    input  logic [CHANNELS*WIDTH-1:0] highcount,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS-1:0]       enable,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       clkout,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       pending
);

    localparam int unsigned W = WIDTH;

    // Divisors below 2 are treated as 2.
    function automatic logic [W-1:0] neff(input logic [W-1:0] n);
        return (n < W'(2)) ? W'(2) : n;
    endfunction

    // Zero high time selects a 50% duty cycle.
    function automatic logic [W-1:0] heff(input logic [W-1:0] n, input logic [W-1:0] h);
        return (h == '0) ? (neff(n) >> 1) : h;
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [W-1:0] cnt;
        logic [W-1:0] act_n;
        logic [W-1:0] act_h;
        logic [W-1:0] sh_n;
        logic [W-1:0] sh_h;
        logic [W-1:0] in_n;
        logic [W-1:0] in_h;
        logic [W-1:0] nxt_n;
        logic [W-1:0] nxt_h;
        logic [W-1:0] cnt_inc;
        logic         start;

        // Values that become active at a period start or while disabled:
        // a coincident load wins, then a pending shadow, else the current set.
        always_comb begin
            in_n    = divideby[i*W +: W];
            in_h    = highcount[i*W +: W];
            nxt_n   = act_n;
            nxt_h   = act_h;
            if (load[i]) begin
                nxt_n = in_n;
                nxt_h = in_h;
            end else if (pending[i]) begin
                nxt_n = sh_n;
                nxt_h = sh_h;
            end
            cnt_inc = cnt + W'(1);
            start   = sync || (cnt == (neff(act_n) - W'(1)));
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                act_n      <= in_n;
                act_h      <= in_h;
                sh_n       <= in_n;
                sh_h       <= in_h;
                cnt        <= neff(in_n) - W'(1);
                clkout[i]  <= 1'b0;
                tick[i]    <= 1'b0;
                pending[i] <= 1'b0;
            end else if (!enable[i]) begin
                // Parked on the last count so the first enabled edge starts a period.
                act_n      <= nxt_n;
                act_h      <= nxt_h;
                if (load[i]) begin
                    sh_n <= in_n;
                    sh_h <= in_h;
                end
                cnt        <= neff(nxt_n) - W'(1);
                clkout[i]  <= 1'b0;
                tick[i]    <= 1'b0;
                pending[i] <= 1'b0;
            end else if (start) begin
                act_n      <= nxt_n;
                act_h      <= nxt_h;
                if (load[i]) begin
                    sh_n <= in_n;
                    sh_h <= in_h;
                end
                cnt        <= '0;
                tick[i]    <= 1'b1;
                clkout[i]  <= (heff(nxt_n, nxt_h) != '0);
                pending[i] <= 1'b0;
            end else begin
                if (load[i]) begin
                    sh_n       <= in_n;
                    sh_h       <= in_h;
                    pending[i] <= 1'b1;
                end
                cnt       <= cnt_inc;
                tick[i]   <= 1'b0;
                clkout[i] <= (cnt_inc < heff(act_n, act_h));
            end
        end
    end

endmodule

// File: tb/tb_clockdiv_multi.sv
// Scoreboard bench for clockdiv_multi: directed per-cycle expectations are
// queued by the stimulus and checked by an independent monitor after each edge.
module tb_clockdiv_multi;

    localparam int unsigned W = 16;
    localparam int unsigned C = 4;

    logic         clk;
    logic         reset;
    logic [C*W-1:0] divideby;
    logic [C*W-1:0] highcount;
    logic [C-1:0] load;
    logic [C-1:0] enable;
    logic         sync;
    logic [C-1:0] clkout;
    logic [C-1:0] tick;
    logic [C-1:0] pending;

    clockdiv_multi #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .divideby  (divideby),
        .highcount (highcount),
        .load      (load),
        .enable    (enable),
        .sync      (sync),
        .clkout    (clkout),
        .tick      (tick),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        logic [3:0] mask;
        logic [3:0] c;
        logic [3:0] t;
        logic [3:0] p;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;

    task automatic push_exp(input logic [3:0] m, input logic [3:0] c, input logic [3:0] t,
                            input logic [3:0] p, input string nm);
        exp_t e;
        e.cyc  = cyc + 1;
        e.mask = m;
        e.c    = c;
        e.t    = t;
        e.p    = p;
        q.push_back(e);
        qn.push_back(nm);
    endtask

    task automatic setch(input int ch, input int n, input int h);
        divideby[ch*W +: W]  = W'(n);
        highcount[ch*W +: W] = W'(h);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Monitor: compare every queued expectation due on this edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e  = q.pop_front();
                nm = qn.pop_front();
                checks++;
                if (e.cyc != cyc ||
                    (clkout & e.mask) != (e.c & e.mask) ||
                    (tick & e.mask) != (e.t & e.mask) ||
                    (pending & e.mask) != (e.p & e.mask)) begin
                    errors++;
                    $display("FAIL %s cyc %0d: got clkout=%b tick=%b pending=%b, expected clkout=%b tick=%b pending=%b (mask %b, due cyc %0d)",
                             nm, cyc, clkout & e.mask, tick & e.mask, pending & e.mask,
                             e.c & e.mask, e.t & e.mask, e.p & e.mask, e.mask, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        divideby  = '0;
        highcount = '0;
        load      = '0;
        enable    = 4'b1111;
        sync      = 1'b0;
        setch(0, 2, 0);
        setch(1, 5, 0);
        setch(2, 0, 0);
        setch(3, 5, 4);
        nxt();

        // Reset state, then N=2/50%, N=5/H0, N=0 (as 2), N=5/H4.
        push_exp(4'b1111, 4'b0000, 4'b0000, 4'b0000, "reset"); nxt();
        reset = 1'b0;
        push_exp(4'b1111, 4'b1111, 4'b1111, 4'b0000, "a1"); nxt();
        push_exp(4'b1111, 4'b1010, 4'b0000, 4'b0000, "a2"); nxt();
        push_exp(4'b1111, 4'b1101, 4'b0101, 4'b0000, "a3"); nxt();
        push_exp(4'b1111, 4'b1000, 4'b0000, 4'b0000, "a4"); nxt();
        push_exp(4'b1111, 4'b0101, 4'b0101, 4'b0000, "a5"); nxt();
        push_exp(4'b1111, 4'b1010, 4'b1010, 4'b0000, "a6"); nxt();

        // Mid-period load on ch1 (N=5,H=7): pending until the next wrap.
        setch(1, 5, 7);
        load = 4'b0010;
        push_exp(4'b0010, 4'b0010, 4'b0000, 4'b0010, "pend_set"); nxt();
        load = 4'b0000;
        push_exp(4'b0010, 4'b0000, 4'b0000, 4'b0010, "pend_hold1"); nxt();
        push_exp(4'b0010, 4'b0000, 4'b0000, 4'b0010, "pend_hold2"); nxt();
        push_exp(4'b0010, 4'b0000, 4'b0000, 4'b0010, "pend_hold3"); nxt();

        // Load on ch3 coincident with its wrap: bypasses the shadow.
        setch(3, 3, 0);
        load = 4'b1000;
        push_exp(4'b0010, 4'b0010, 4'b0010, 4'b0000, "pend_apply");
        push_exp(4'b1000, 4'b1000, 4'b1000, 4'b0000, "wrap_load"); nxt();
        load = 4'b0000;
        push_exp(4'b1010, 4'b0010, 4'b0000, 4'b0000, "b12"); nxt();
        push_exp(4'b1010, 4'b0010, 4'b0000, 4'b0000, "b13"); nxt();
        push_exp(4'b1010, 4'b1010, 4'b1000, 4'b0000, "b14"); nxt();
        push_exp(4'b1010, 4'b0010, 4'b0000, 4'b0000, "b15"); nxt();
        push_exp(4'b1010, 4'b0010, 4'b0010, 4'b0000, "const_hi_tick"); nxt();

        // Fresh start: ch0 N=4, ch1 N=6, ch2 N=2, ch3 N=3 disabled.
        reset  = 1'b1;
        enable = 4'b0111;
        setch(0, 4, 0);
        setch(1, 6, 0);
        setch(2, 2, 0);
        setch(3, 3, 0);
        push_exp(4'b1111, 4'b0000, 4'b0000, 4'b0000, "reset2"); nxt();
        reset = 1'b0;
        push_exp(4'b1111, 4'b0111, 4'b0111, 4'b0000, "c1"); nxt();
        push_exp(4'b1111, 4'b0011, 4'b0000, 4'b0000, "c2"); nxt();
        push_exp(4'b1111, 4'b0110, 4'b0100, 4'b0000, "c3"); nxt();
        push_exp(4'b1111, 4'b0000, 4'b0000, 4'b0000, "c4"); nxt();
        push_exp(4'b1111, 4'b0101, 4'b0101, 4'b0000, "c5"); nxt();
        sync = 1'b1;
        push_exp(4'b1111, 4'b0111, 4'b0111, 4'b0000, "sync_align"); nxt();
        sync = 1'b0;
        push_exp(4'b1111, 4'b0011, 4'b0000, 4'b0000, "c7"); nxt();
        push_exp(4'b1111, 4'b0110, 4'b0100, 4'b0000, "c8"); nxt();

        // Drop ch1 mid-high-phase, bring ch3 up.
        enable = 4'b1101;
        push_exp(4'b1111, 4'b1000, 4'b1000, 4'b0000, "en_drop"); nxt();
        setch(1, 4, 1);
        load = 4'b0010;
        push_exp(4'b1111, 4'b0101, 4'b0101, 4'b0000, "dis_load"); nxt();
        load   = 4'b0000;
        enable = 4'b1111;
        push_exp(4'b1111, 4'b0011, 4'b0010, 4'b0000, "reenable"); nxt();
        push_exp(4'b1111, 4'b1100, 4'b1100, 4'b0000, "c12"); nxt();

        // Reset mid-period with a new ch0 divisor (N=3, H=2).
        reset = 1'b1;
        setch(0, 3, 2);
        push_exp(4'b1111, 4'b0000, 4'b0000, 4'b0000, "reset3"); nxt();
        reset = 1'b0;
        push_exp(4'b1111, 4'b1111, 4'b1111, 4'b0000, "d1"); nxt();
        push_exp(4'b1111, 4'b0001, 4'b0000, 4'b0000, "d2"); nxt();
        push_exp(4'b1111, 4'b0100, 4'b0100, 4'b0000, "d3"); nxt();
        push_exp(4'b1111, 4'b1001, 4'b1001, 4'b0000, "d4"); nxt();

        repeat (3) nxt();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clockdiv_multi.md
Name: clockdiv_multi

Overview:
- Parametrised, multi-channel successor to the single-channel programmable clock divider.
- Each channel divides clk by a programmable integer and supports a programmable high time (duty cycle).
- Divisor and high-time updates are double-buffered and applied only at period boundaries, so outputs never glitch.
- A common sync input phase-aligns all channels. Outputs are registered enables/clock-like strobes for peripheral timing inside the clk domain.

Parameters:
- WIDTH, 16, bit width of each channel's divisor, high-time and counter.
- CHANNELS, 4, number of independent divider channels (>=1).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- divideby  in  CHANNELS*WIDTH  per-channel divisor N; channel i occupies bits [i*WIDTH +: WIDTH].
- highcount  in  CHANNELS*WIDTH  per-channel high time H in clk cycles; 0 selects 50% duty.
- load  in  CHANNELS  per-channel strobe; captures that channel's divideby/highcount into its shadow register.
- enable  in  CHANNELS  per-channel run enable.
- sync  in  1  restarts the period of every enabled channel on this edge.
- clkout  out  CHANNELS  divided outputs (registered).
- tick  out  CHANNELS  one-cycle pulse on the first cycle of each period.
- pending  out  CHANNELS  a shadow update is waiting for the next period boundary.

Behaviour:
- Effective values per channel:
  - N_eff = max(N, 2).
  - H_eff = floor(N_eff/2) if H == 0, else H.
  - If H_eff >= N_eff, clkout stays 1 while enabled.
  - All compares are unsigned, WIDTH bits.
- State per channel: cnt[WIDTH], active N and H, shadow N and H, pending flag, clkout register, tick register.
- Edge priority per channel: reset > enable low > sync > wrap > count.
- Reset (sync, active-high):
  - Active and shadow registers load from the divideby/highcount inputs; cnt <= N_eff-1.
  - clkout = 0, tick = 0, pending = 0.
- Enable low:
  - cnt is held at N_eff-1; clkout <= 0; tick <= 0.
  - Any pending shadow is copied to active immediately and pending clears.
  - Consequence: the first edge after enable rises is a period start.
- Count: if cnt == N_eff-1 the channel wraps (period start), else cnt <= cnt+1.
- Period start (wrap or sync while enabled):
  - cnt <= 0; tick <= 1.
  - If pending is set, active <= shadow and pending <= 0.
  - clkout <= (0 < H_eff), evaluated with the newly active values.
- Otherwise clkout <= (cnt_next < H_eff) and tick <= 0.
- clkout therefore equals 1 for exactly H_eff cycles and 0 for N_eff-H_eff cycles per period, starting on the tick cycle.
- Load:
  - load[i] captures the inputs into shadow and sets pending (pending visible the next cycle).
  - Load on the same edge as a period start bypasses the shadow: the just-presented values become active at that start and pending stays 0.
  - Load while enable is low takes effect immediately.
  - Repeated loads before a boundary: the last one wins.
- Sync: affects only enabled channels; disabled channels ignore it. Sync while a period is mid-way truncates that period.
- Reset mid-operation: state is discarded and values are reloaded from the inputs as above, with no partial period.
- Channels are fully independent apart from the shared sync.
- No combinational path from inputs to outputs.

Test Plan:
- Reset with divideby=2, highcount=0, enable=1 and reset released -> clkout 1,0,1,0...; tick high on every clkout-high cycle; first tick on the first edge after reset falls.
- Channel 1: N=5, H=0 -> clkout 1,1,0,0,0 repeating (H_eff=2). N=5, H=4 -> 1,1,1,1,0. N=5, H=7 -> constant 1 with tick every 5 cycles. N=0 or 1 -> behaves as N=2.
- Mid-period load of N=3 onto a running N=8 channel -> pending=1 until the next wrap. The old 8-cycle period completes; the next period is 3 cycles with H_eff=1; pending clears on that tick.
- Load coincident with the wrap edge -> new values are used for that same period; pending never asserts.
- Channels at N=4 and N=6 running out of phase, sync pulsed -> both tick and go high on the same edge. A disabled channel 3 remains low with cnt unchanged.
- Enable dropped mid-high-phase -> clkout 0 on the next edge. Re-enable -> tick and clkout=1 on the first enabled edge. Reset asserted mid-period -> all outputs 0 the next cycle and new divisor values are captured.
